// File: rtl/pll_sup_pkg.sv
// Shared types and default timing for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_sup_state_t;

  localparam int DEF_RST_CYCLES          = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES         = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies the synchronized lock, and releases the downstream
// reset only after sustained lock; retries on timeout and latches a fault.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES          = DEF_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

  pll_sup_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             lk;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state         <= HOLD;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      // A drop seen in RUN is counted even when a relock request wins the transition.
      if (state == RUN && !lk && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;

      if (relock_req) begin
        state     <= HOLD;
        cnt       <= '0;
        retry_cnt <= '0;
      end else begin
        case (state)
          HOLD: begin
            if (cnt == RST_LAST) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lk) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == TMO_LAST) begin
              cnt <= '0;
              if (retry_cnt == MAX_R) begin
                state <= FAULT;
              end else begin
                retry_cnt <= retry_cnt + 4'd1;
                state     <= HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STABLE: begin
            if (!lk) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (!lk) begin
              state <= HOLD;
              cnt   <= '0;
            end
          end
          FAULT: ;
          default: begin
            state <= HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign pll_rst   = (state == HOLD) || (state == FAULT);
  assign sys_rst_n = (state == RUN);
  assign ready     = (state == RUN);
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized and directed bench for pll_lock_supervisor against a timestamp-based
// reference model of the lock sequencing rules.
module tb_pll_lock_supervisor;

  localparam int R  = 4;
  localparam int L  = 8;
  localparam int T  = 32;
  localparam int MR = 2;

  localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAULT = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pll_lock_supervisor #(
    .RST_CYCLES          (R),
    .LOCK_STABLE_CYCLES  (L),
    .LOCK_TIMEOUT_CYCLES (T),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase plus entry timestamp; lk is the raw sample taken two
  // edges earlier, zero if that edge was at or before the last reset edge.
  int m_n = 0, m_rlast = 0, m_t0 = 0, m_ph = PH_HOLD, m_retry = 0, m_loss = 0;
  bit m_smp [4];

  always @(posedge refclk) begin
    bit lk;
    m_n++;
    lk = (m_n - 2 > m_rlast) ? m_smp[(m_n - 2) % 4] : 1'b0;
    m_smp[m_n % 4] = pll_locked;
    if (!rst_n) begin
      m_rlast = m_n; m_ph = PH_HOLD; m_t0 = m_n; m_retry = 0; m_loss = 0;
    end else begin
      if (m_ph == PH_RUN && !lk && m_loss < 255) m_loss++;
      if (relock_req) begin
        m_ph = PH_HOLD; m_t0 = m_n; m_retry = 0;
      end else if (m_ph == PH_HOLD) begin
        if (m_n - m_t0 == R) begin m_ph = PH_WAIT; m_t0 = m_n; end
      end else if (m_ph == PH_WAIT) begin
        if (lk) begin m_ph = PH_STAB; m_t0 = m_n; end
        else if (m_n - m_t0 == T) begin
          m_t0 = m_n;
          if (m_retry == MR) m_ph = PH_FAULT;
          else begin m_retry++; m_ph = PH_HOLD; end
        end
      end else if (m_ph == PH_STAB) begin
        if (!lk) begin m_ph = PH_WAIT; m_t0 = m_n; end
        else if (m_n - m_t0 == L) m_ph = PH_RUN;
      end else if (m_ph == PH_RUN) begin
        if (!lk) begin m_ph = PH_HOLD; m_t0 = m_n; end
      end
    end
  end

  always @(negedge refclk) begin
    if (chk_en) begin
      chk("m_pll_rst",   pll_rst,       (m_ph == PH_HOLD || m_ph == PH_FAULT));
      chk("m_sys_rst_n", sys_rst_n,     (m_ph == PH_RUN));
      chk("m_ready",     ready,         (m_ph == PH_RUN));
      chk("m_fault",     fault,         (m_ph == PH_FAULT));
      chk("m_retry",     retry_cnt,     m_retry);
      chk("m_loss",      lock_loss_cnt, m_loss);
    end
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic wait_ready(input logic v, input int lim, output int t);
    t = 0;
    while (ready !== v && t < lim) begin tick(); t++; end
    chk("ready_wait", ready, v);
  endtask

  task automatic hi_run(output int len);
    len = 0;
    while (pll_rst === 1'b1 && len < 100) begin len++; tick(); end
  endtask

  task automatic lo_run(output int len);
    len = 0;
    while (pll_rst === 1'b0 && len < 100) begin len++; tick(); end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_loss"}, lock_loss_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, len, hold;
    tick(); tick();
    chk_en = 1'b1;
    chk_reset_vals("reset");

    // Clean lock
    rst_n = 1'b1;
    hi_run(len);
    chk("first_rst_pulse", len, R);
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_ready(1'b1, 40, t);
    chk("lock_to_ready", t, L + 3);
    chk("clean_sys_rst_n", sys_rst_n, 1);
    chk("clean_retry", retry_cnt, 0);

    // Loss in RUN
    repeat (3) tick();
    pll_locked = 1'b0;
    wait_ready(1'b0, 10, t);
    chk("drop_to_ready_low", t, 3);
    chk("loss_one", lock_loss_cnt, 1);
    pll_locked = 1'b1;
    hi_run(len);
    chk("loss_rst_pulse", len, R);
    wait_ready(1'b1, 40, t);
    chk("relock_time", t, L + 1);

    // Glitch in STABLE
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_ready(1'b1, 40, t2);
    chk("glitch_ready_time", 12 + t2, 23);

    // No lock: three attempts, then fault
    relock_req = 1'b1; pll_locked = 1'b0; tick(); relock_req = 1'b0;
    for (int p = 0; p < 3; p++) begin
      hi_run(len);
      chk("nolock_hi", len, R);
      lo_run(len);
      chk("nolock_lo", len, T);
    end
    chk("fault_set", fault, 1);
    chk("fault_pll_rst", pll_rst, 1);
    chk("fault_retry", retry_cnt, MR);
    repeat (100) tick();
    chk("fault_sticky", fault, 1);

    // Recover from FAULT
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    chk("recover_fault", fault, 0);
    chk("recover_retry", retry_cnt, 0);
    hi_run(len);
    chk("recover_pulse", len, R);
    pll_locked = 1'b1;
    wait_ready(1'b1, 40, t);

    // Randomized traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        if (pll_locked) hold = $urandom_range(5, 60);
        else hold = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 120) : $urandom_range(1, 10);
      end
      hold--;
      relock_req = ($urandom_range(0, 199) == 0);
      rst_n      = ($urandom_range(0, 599) != 0);
      tick();
    end
    relock_req = 1'b0; rst_n = 1'b1;

    // Saturate lock_loss_cnt, then reset mid-STABLE
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pll_locked = 1'b1;
    wait_ready(1'b1, 60, t);
    for (int k = 0; k < 256; k++) begin
      pll_locked = 1'b0; tick(); pll_locked = 1'b1;
      t = 0; while (ready !== 1'b0 && t < 10) begin tick(); t++; end
      t = 0; while (ready !== 1'b1 && t < 40) begin tick(); t++; end
    end
    chk("loss_saturated", lock_loss_cnt, 255);
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_ready(1'b0, 10, t);
    repeat (8) tick();
    chk("in_stable_not_ready", ready, 0);
    chk("loss_before_reset", lock_loss_cnt, 255);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_reset_vals("midreset");
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
